// File: rtl/rob_retire_ctrl_pkg.sv
// rtl/rob_retire_ctrl_pkg.sv - shared ROB sizing constants and entry payload type
package rob_retire_ctrl_pkg;

    localparam int ROB_DEPTH = 64;
    localparam int ROB_IDX_W = 6;
    localparam int PREG_W    = 6;
    localparam int PC_W      = 32;
    localparam int RET_W     = 2;
    localparam int CNT_W     = ROB_IDX_W + 1;

    // Payload captured at dispatch and replayed at retire
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [PREG_W-1:0] dest;
        logic [PREG_W-1:0] old_dest;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire_ctrl_if.sv
// rtl/rob_retire_ctrl_if.sv - dispatch/writeback/retire bundle of the ROB sequencer
// Ports: alloc_* (dispatch handshake), cmpl0_*/cmpl1_* (writeback), ret0_*/ret1_* (retire),
// rob_count (occupancy). master = pipeline side, slave = ROB sequencer.
interface rob_retire_ctrl_if;
    import rob_retire_ctrl_pkg::*;

    logic                 alloc_valid;
    logic                 alloc_ready;
    logic [ROB_IDX_W-1:0] alloc_rob_idx;
    logic [PC_W-1:0]      alloc_pc;
    logic [PREG_W-1:0]    alloc_dest;
    logic [PREG_W-1:0]    alloc_old_dest;
    logic                 cmpl0_valid;
    logic [ROB_IDX_W-1:0] cmpl0_idx;
    logic                 cmpl1_valid;
    logic [ROB_IDX_W-1:0] cmpl1_idx;
    logic                 ret0_valid;
    logic [PC_W-1:0]      ret0_pc;
    logic [PREG_W-1:0]    ret0_dest;
    logic [PREG_W-1:0]    ret0_old_dest;
    logic                 ret1_valid;
    logic [PC_W-1:0]      ret1_pc;
    logic [PREG_W-1:0]    ret1_dest;
    logic [PREG_W-1:0]    ret1_old_dest;
    logic [CNT_W-1:0]     rob_count;

    modport master (
        output alloc_valid, alloc_pc, alloc_dest, alloc_old_dest,
        output cmpl0_valid, cmpl0_idx, cmpl1_valid, cmpl1_idx,
        input  alloc_ready, alloc_rob_idx,
        input  ret0_valid, ret0_pc, ret0_dest, ret0_old_dest,
        input  ret1_valid, ret1_pc, ret1_dest, ret1_old_dest,
        input  rob_count
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_dest, alloc_old_dest,
        input  cmpl0_valid, cmpl0_idx, cmpl1_valid, cmpl1_idx,
        output alloc_ready, alloc_rob_idx,
        output ret0_valid, ret0_pc, ret0_dest, ret0_old_dest,
        output ret1_valid, ret1_pc, ret1_dest, ret1_old_dest,
        output rob_count
    );

endinterface

// File: rtl/rob_retire_ctrl_ptr.sv
// rtl/rob_retire_ctrl_ptr.sv - wrap-around ROB pointer advancing by 0, 1 or 2 per cycle
// Ports: clk, rstn (async active-low), clr (sync return to 0), inc (step 0..2), ptr (current value).
module rob_ptr
    import rob_retire_ctrl_pkg::*;
#(
    parameter int W = ROB_IDX_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic [1:0]   inc,
    output logic [W-1:0] ptr
);

    // Depth is a power of two, so natural W-bit overflow is the modulo wrap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else begin
            ptr <= ptr + W'(inc);
        end
    end

endmodule

// File: rtl/rob_retire_ctrl.sv
// rtl/rob_retire_ctrl.sv - ROB allocation, completion tracking and dual in-order retire
// Ports: clk, rstn (async active-low), flush (sync discard of all entries),
// rif (slave side of rob_retire_ctrl_if: dispatch, two writeback ports, two retire slots, count).
module rob_retire_ctrl
    import rob_retire_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    rob_retire_ctrl_if.slave   rif
);

    logic [ROB_DEPTH-1:0] valid_q;
    logic [ROB_DEPTH-1:0] complete_q;
    rob_entry_t           entry_q [ROB_DEPTH];
    logic [ROB_IDX_W-1:0] head;
    logic [ROB_IDX_W-1:0] tail;
    logic [ROB_IDX_W-1:0] head_p1;
    logic [CNT_W-1:0]     count_q;
    logic                 fire;
    logic                 r0;
    logic                 r1;
    logic [1:0]           ret_n;
    logic [1:0]           alloc_n;

    // Readiness looks only at current occupancy: a full ROB refuses dispatch
    // even in a cycle that retires.
    assign rif.alloc_ready   = (count_q != CNT_W'(ROB_DEPTH));
    assign rif.alloc_rob_idx = tail;
    assign rif.rob_count     = count_q;

    assign fire    = rif.alloc_valid & rif.alloc_ready;
    assign head_p1 = head + ROB_IDX_W'(1);

    // Second slot only retires behind the first, keeping retire strictly in order
    assign r0      = valid_q[head] & complete_q[head];
    assign r1      = r0 & valid_q[head_p1] & complete_q[head_p1];
    assign ret_n   = {1'b0, r0} + {1'b0, r1};
    assign alloc_n = {1'b0, fire};

    rob_ptr #(.W(ROB_IDX_W)) u_head (
        .clk  (clk),
        .rstn (rstn),
        .clr  (flush),
        .inc  (ret_n),
        .ptr  (head)
    );

    rob_ptr #(.W(ROB_IDX_W)) u_tail (
        .clk  (clk),
        .rstn (rstn),
        .clr  (flush),
        .inc  (alloc_n),
        .ptr  (tail)
    );

    // Payload array needs no reset: it is only read through VALID-qualified retire
    always_ff @(posedge clk) begin
        if (fire && !flush) begin
            entry_q[tail] <= '{pc: rif.alloc_pc, dest: rif.alloc_dest, old_dest: rif.alloc_old_dest};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q           <= '0;
            complete_q        <= '0;
            count_q           <= '0;
            rif.ret0_valid    <= 1'b0;
            rif.ret0_pc       <= '0;
            rif.ret0_dest     <= '0;
            rif.ret0_old_dest <= '0;
            rif.ret1_valid    <= 1'b0;
            rif.ret1_pc       <= '0;
            rif.ret1_dest     <= '0;
            rif.ret1_old_dest <= '0;
        end else if (flush) begin
            valid_q        <= '0;
            complete_q     <= '0;
            count_q        <= '0;
            rif.ret0_valid <= 1'b0;
            rif.ret1_valid <= 1'b0;
        end else begin
            // Writebacks to unallocated slots are stale and dropped
            if (rif.cmpl0_valid && valid_q[rif.cmpl0_idx]) begin
                complete_q[rif.cmpl0_idx] <= 1'b1;
            end
            if (rif.cmpl1_valid && valid_q[rif.cmpl1_idx]) begin
                complete_q[rif.cmpl1_idx] <= 1'b1;
            end
            // Retire clears come after completion sets so a retiring slot ends empty
            if (r0) begin
                valid_q[head]    <= 1'b0;
                complete_q[head] <= 1'b0;
            end
            if (r1) begin
                valid_q[head_p1]    <= 1'b0;
                complete_q[head_p1] <= 1'b0;
            end
            // Tail never aliases a live slot because a full ROB blocks fire
            if (fire) begin
                valid_q[tail]    <= 1'b1;
                complete_q[tail] <= 1'b0;
            end
            count_q        <= count_q + CNT_W'(fire) - CNT_W'(ret_n);
            rif.ret0_valid <= r0;
            rif.ret1_valid <= r1;
            if (r0) begin
                rif.ret0_pc       <= entry_q[head].pc;
                rif.ret0_dest     <= entry_q[head].dest;
                rif.ret0_old_dest <= entry_q[head].old_dest;
            end
            if (r1) begin
                rif.ret1_pc       <= entry_q[head_p1].pc;
                rif.ret1_dest     <= entry_q[head_p1].dest;
                rif.ret1_old_dest <= entry_q[head_p1].old_dest;
            end
        end
    end

endmodule
